fp_mul_arbiter: RTL and testbench

//  Shares one pipelined fp_mul instance between two requesters (contexts 0/1) of the

---
 rtl/fp_mul_arbiter.sv | 125 ++++++++++++
 tb/tb_fp_mul_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin share of one pipelined fp_mul between two requesters. A tag pipeline
// running in lockstep with the multiplier routes each product back to its issuer.
module fp_mul_arbiter #(
    parameter int FLOAT_DATA_WIDTH = 32,
    parameter int MUL_LATENCY      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        req_0,
    input  logic [FLOAT_DATA_WIDTH-1:0] dataa_0,
    input  logic [FLOAT_DATA_WIDTH-1:0] datab_0,
    output logic                        gnt_0,
    input  logic                        req_1,
    input  logic [FLOAT_DATA_WIDTH-1:0] dataa_1,
    input  logic [FLOAT_DATA_WIDTH-1:0] datab_1,
    output logic                        gnt_1,
    output logic                        mul_clk_en,
    output logic [FLOAT_DATA_WIDTH-1:0] mul_dataa,
    output logic [FLOAT_DATA_WIDTH-1:0] mul_datab,
    input  logic [FLOAT_DATA_WIDTH-1:0] mul_result,
    output logic [FLOAT_DATA_WIDTH-1:0] result_0,
    output logic                        valid_0,
    output logic [FLOAT_DATA_WIDTH-1:0] result_1,
    output logic                        valid_1,
    output logic                        busy
);

    logic                        rr_q, rr_d;
    logic                        any_req;
    logic                        win_id;
    logic                        issue;
    logic [MUL_LATENCY-1:0]      tag_vld_q;
    logic [MUL_LATENCY-1:0]      tag_id_q;
    logic                        valid_0_q, valid_0_d;
    logic                        valid_1_q, valid_1_d;
    logic [FLOAT_DATA_WIDTH-1:0] result_0_q, result_0_d;
    logic [FLOAT_DATA_WIDTH-1:0] result_1_q, result_1_d;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        any_req = req_0 | req_1;
        win_id  = (req_0 & req_1) ? ~rr_q : req_1;
        issue   = clk_en & any_req;
        gnt_0   = issue & ~win_id;
        gnt_1   = issue & win_id;
        rr_d    = issue ? win_id : rr_q;
    end

    always_comb begin
        mul_dataa = '0;
        mul_datab = '0;
        if (any_req) begin
            mul_dataa = win_id ? dataa_1 : dataa_0;
            mul_datab = win_id ? datab_1 : datab_0;
        end
    end

    assign mul_clk_en = clk_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Tag stages shift only on enabled edges so they stay aligned with fp_mul.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        tag_vld_q[gi] <= 1'b0;
                        tag_id_q[gi]  <= 1'b0;
                    end else if (clk_en) begin
                        tag_vld_q[gi] <= issue;
                        tag_id_q[gi]  <= win_id;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        tag_vld_q[gi] <= 1'b0;
                        tag_id_q[gi]  <= 1'b0;
                    end else if (clk_en) begin
                        tag_vld_q[gi] <= tag_vld_q[gi-1];
                        tag_id_q[gi]  <= tag_id_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Valid pulses clear on every edge, enabled or not, so they last one cycle.
    always_comb begin
        valid_0_d  = clk_en & tag_vld_q[MUL_LATENCY-1] & ~tag_id_q[MUL_LATENCY-1];
        valid_1_d  = clk_en & tag_vld_q[MUL_LATENCY-1] & tag_id_q[MUL_LATENCY-1];
        result_0_d = valid_0_d ? mul_result : result_0_q;
        result_1_d = valid_1_d ? mul_result : result_1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_0_q  <= 1'b0;
            valid_1_q  <= 1'b0;
            result_0_q <= '0;
            result_1_q <= '0;
        end else begin
            valid_0_q  <= valid_0_d;
            valid_1_q  <= valid_1_d;
            result_0_q <= result_0_d;
            result_1_q <= result_1_d;
        end
    end

    assign valid_0  = valid_0_q;
    assign valid_1  = valid_1_q;
    assign result_0 = result_0_q;
    assign result_1 = result_1_q;
    assign busy     = (|tag_vld_q) | valid_0_q | valid_1_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural pipelined fp_mul and an
// in-order scoreboard of {requester, product, expected enabled-edge count}.
module tb_fp_mul_arbiter;
    localparam int W = 32;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst, clk_en, req_0, req_1;
    logic [W-1:0] dataa_0, datab_0, dataa_1, datab_1;
    logic         gnt_0, gnt_1, mul_clk_en, valid_0, valid_1, busy;
    logic [W-1:0] mul_dataa, mul_datab, mul_result, result_0, result_1;
    logic [W-1:0] mpipe [L];

    typedef struct {
        bit          id;
        logic [31:0] val;
        int          target;
    } exp_t;
    exp_t sbq[$];

    int tests = 0;
    int fails = 0;
    int e_cnt = 0;
    bit last_en = 1'b0;
    int a0, b0, a1, b1;
    bit g0, g1;
    int gcount0 = 0;

    always #5 clk = ~clk;

    fp_mul_arbiter #(.FLOAT_DATA_WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_0(req_0), .dataa_0(dataa_0), .datab_0(datab_0), .gnt_0(gnt_0),
        .req_1(req_1), .dataa_1(dataa_1), .datab_1(datab_1), .gnt_1(gnt_1),
        .mul_clk_en(mul_clk_en), .mul_dataa(mul_dataa), .mul_datab(mul_datab),
        .mul_result(mul_result),
        .result_0(result_0), .valid_0(valid_0),
        .result_1(result_1), .valid_1(valid_1), .busy(busy)
    );

    // Truncating single-precision multiply for normal operands (stand-in for fp_mul).
    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          ex;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
        p  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        ex = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            ex++;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], ex[7:0], m};
    endfunction

    // Positive integer (< 2^24) to single precision.
    function automatic logic [31:0] i2f(int n);
        int          p;
        logic [31:0] m32;
        logic [7:0]  ex;
        p = 0;
        for (int i = 0; i < 31; i++) if (((n >> i) & 1) == 1) p = i;
        m32 = 32'(n) << (23 - p);
        ex  = 8'(127 + p);
        return {1'b0, ex, m32[22:0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) mpipe[i] <= '0;
        end else if (mul_clk_en) begin
            mpipe[0] <= fmul(mul_dataa, mul_datab);
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_result = mpipe[L-1];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        dataa_0 = i2f(a0);
        datab_0 = i2f(b0);
        dataa_1 = i2f(a1);
        datab_1 = i2f(b1);
    endtask

    task automatic mon();
        g0 = gnt_0;
        g1 = gnt_1;
        check("gnt_exclusive", {31'd0, g0 & g1}, 32'd0);
        if (g0) begin
            sbq.push_back('{1'b0, i2f(a0 * b0), e_cnt + L + 1});
            gcount0++;
        end
        if (g1) sbq.push_back('{1'b1, i2f(a1 * b1), e_cnt + L + 1});
        if (valid_0 || valid_1) begin
            check("valid_exclusive", {31'd0, valid_0 & valid_1}, 32'd0);
            check("busy_with_valid", {31'd0, busy}, 32'd1);
            if (sbq.size() == 0) begin
                check("unexpected_valid", {30'd0, valid_1, valid_0}, 32'd0);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                check("valid_id", {31'd0, valid_1}, {31'd0, x.id});
                check("result", x.id ? result_1 : result_0, x.val);
                check("latency_edges", e_cnt, x.target);
                $display("[TB] result id=%0d value=%h edge=%0d", x.id, x.id ? result_1 : result_0, e_cnt);
            end
        end else if (sbq.size() > 0 && last_en && sbq[0].target <= e_cnt) begin
            check("missing_valid", {31'd0, valid_0 | valid_1}, 32'd1);
            void'(sbq.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        last_en = clk_en;
        if (clk_en && !rst) e_cnt++;
        #1;
        if (g0) a0++;
        if (g1) a1++;
        drive();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sbq.size() > 0; i++) tick();
        check("drain_empty", sbq.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sbq.delete();
        last_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
        a0 = 2; b0 = 3; a1 = 1; b1 = 1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_0", {31'd0, valid_0}, 32'd0);
        check("rst_valid_1", {31'd0, valid_1}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result_0", result_0, 32'd0);
        check("rst_result_1", result_1, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_gnt_0", {31'd0, gnt_0}, 32'd0);
        check("idle_mul_dataa", mul_dataa, 32'd0);

        // Single op 2.0 * 3.0
        req_0 = 1'b1;
        #1;
        check("t1_gnt_0", {31'd0, gnt_0}, 32'd1);
        check("t1_mul_dataa", mul_dataa, 32'h40000000);
        tick();
        req_0 = 1'b0;
        drain();
        check("t1_result_0", result_0, 32'h40C00000);

        // Contention right after reset: 0,1,0,1
        do_reset();
        a0 = 1; b0 = 5; a1 = 7; b1 = 2;
        drive();
        req_0 = 1'b1; req_1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_gnt_0", {31'd0, gnt_0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_gnt_1", {31'd0, gnt_1}, (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        req_0 = 1'b0; req_1 = 1'b0;
        drain();

        // Stall three cycles mid-flight
        a1 = 5; b1 = 6;
        drive();
        req_1 = 1'b1;
        tick();
        req_1 = 1'b0;
        tick();
        clk_en = 1'b0;
        req_0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_gnt_0_stall", {31'd0, gnt_0}, 32'd0);
            check("t3_mul_clk_en", {31'd0, mul_clk_en}, 32'd0);
            tick();
        end
        req_0 = 1'b0;
        clk_en = 1'b1;
        drain();
        check("t3_result_1", result_1, 32'h41F00000);

        // Reset while ops are in flight and a pulse is showing
        a0 = 1; b0 = 1;
        drive();
        req_0 = 1'b1;
        repeat (5) tick();
        check("t4_pre_valid_0", {31'd0, valid_0}, 32'd1);
        req_0 = 1'b0;
        rst = 1'b1;
        #1;
        check("t4_valid_0", {31'd0, valid_0}, 32'd0);
        check("t4_valid_1", {31'd0, valid_1}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_result_0", result_0, 32'd0);
        check("t4_result_1", result_1, 32'd0);
        sbq.delete();
        last_en = 1'b0;
        g0 = 1'b0; g1 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) tick();
        req_0 = 1'b1; req_1 = 1'b1;
        #1;
        check("t4_tie_gnt_0", {31'd0, gnt_0}, 32'd1);
        check("t4_tie_gnt_1", {31'd0, gnt_1}, 32'd0);
        tick();
        req_0 = 1'b0; req_1 = 1'b0;
        drain();

        // Streaming 20 ops on requester 0
        a0 = 1; b0 = 3;
        drive();
        req_0 = 1'b1;
        gcount0 = 0;
        repeat (20) tick();
        req_0 = 1'b0;
        check("t5_grants", gcount0, 32'd20);
        drain();
        check("t5_busy_after", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
